// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding request, a single-entry instruction
// buffer toward decode, branch redirects that respect the delay slot, and flush.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'hBFC00000,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        empty,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        PC_modified,
    input  logic [31:0] PC_modified_data,
    input  logic        DE_enable,
    output logic        IF_ready,
    output logic [31:0] inst_out,
    output logic [31:0] IF_PC,
    output logic [4:0]  exccode_out,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    localparam logic [4:0] EXC_ADEL = 5'h04;

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_CANCEL = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [4:0]  exc_q, exc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    logic        flush;
    logic [31:0] flush_tgt;
    logic        misaligned;
    logic        req_fire;
    logic        handoff;
    logic [31:0] next_pc;

    assign flush      = empty | eret;
    assign flush_tgt  = empty ? EXC_VECTOR : epc;
    assign misaligned = |pc_q[1:0];
    assign req_fire   = (state_q == S_REQ) && !misaligned && inst_addr_ok;
    assign handoff    = (state_q == S_HOLD) && DE_enable;
    // A same-cycle branch overrides an older pending target.
    assign next_pc    = PC_modified ? PC_modified_data :
                        pend_q      ? pend_tgt_q       :
                                      if_pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        inst_d     = inst_q;
        exc_d      = exc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;

        if (flush) begin
            pend_d = 1'b0;
            pc_d   = flush_tgt;
            unique case (state_q)
                S_REQ:    state_d = req_fire ? S_CANCEL : S_REQ;
                S_WAIT:   state_d = inst_data_ok ? S_REQ : S_CANCEL;
                S_HOLD:   state_d = S_REQ;
                // Once the stale data has returned there is nothing left to drop.
                S_CANCEL: state_d = inst_data_ok ? S_REQ : S_CANCEL;
                default:  state_d = S_REQ;
            endcase
        end else begin
            if (PC_modified && (state_q != S_CANCEL) && !handoff) begin
                pend_d     = 1'b1;
                pend_tgt_d = PC_modified_data;
            end
            unique case (state_q)
                S_REQ: begin
                    if (misaligned) begin
                        state_d = S_HOLD;
                        inst_d  = 32'h0;
                        exc_d   = EXC_ADEL;
                        if_pc_d = pc_q;
                    end else if (inst_addr_ok) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        state_d = S_HOLD;
                        inst_d  = inst_rdata;
                        exc_d   = 5'h0;
                        if_pc_d = pc_q;
                    end
                end
                S_HOLD: begin
                    if (DE_enable) begin
                        state_d = S_REQ;
                        pc_d    = next_pc;
                        pend_d  = 1'b0;
                    end
                end
                S_CANCEL: begin
                    if (inst_data_ok) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            if_pc_q    <= RESET_PC;
            inst_q     <= 32'h0;
            exc_q      <= 5'h0;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            inst_q     <= inst_d;
            exc_q      <= exc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign inst_req    = (state_q == S_REQ) && !misaligned;
    assign inst_addr   = pc_q;
    assign IF_ready    = (state_q == S_HOLD);
    assign inst_out    = inst_q;
    assign IF_PC       = if_pc_q;
    assign exccode_out = exc_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameters: RESET_PC, default 32'hBFC00000, the first fetch address; EXC_VECTOR, default 32'hBFC00380, the exception entry address.
REQ-002 SHALL have these ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- empty  in  1  exception flush; redirects fetch to EXC_VECTOR.
- eret  in  1  eret commit; redirects fetch to epc.
- epc  in  32  eret return address.
- PC_modified  in  1  branch/jump taken in decode.
- PC_modified_data  in  32  branch/jump target.
- DE_enable  in  1  decode can accept an instruction.
- IF_ready  out  1  fetched instruction valid for decode.
- inst_out  out  32  held instruction word.
- IF_PC  out  32  PC of held instruction.
- exccode_out  out  5  5'h04 = AdEL on fetch, else 0.
- inst_req  out  1  memory request valid.
- inst_addr  out  32  memory request address.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  read data valid this cycle.
- inst_rdata  in  32  read data.

Function
REQ-003 SHALL implement states REQ (address phase), WAIT (data phase), HOLD (instruction buffered) and CANCEL (discard in-flight data).
REQ-004 SHALL keep a fetch PC register; inst_addr SHALL equal the fetch PC.
REQ-005 inst_req SHALL be 1 only in REQ with fetch PC[1:0]==0.
REQ-006 REQ, inst_addr_ok=1 -> WAIT.
REQ-007 REQ with fetch PC[1:0]!=0 SHALL go to HOLD with inst_out=0, exccode_out=5'h04 and no memory request.
REQ-008 WAIT, inst_data_ok=1 -> HOLD, latching inst_rdata into inst_out with exccode_out=0.
REQ-009 Data SHALL return no earlier than the cycle after inst_addr_ok; at most one request SHALL be outstanding.
REQ-010 IF_ready SHALL be 1 only in HOLD; handoff occurs when IF_ready && DE_enable.
REQ-011 On handoff the stage SHALL go to REQ with fetch PC = next PC, where next PC is:
- PC_modified_data if PC_modified is 1 in the same cycle;
- else the pending target if a redirect is pending;
- else IF_PC+4.
The pending-redirect flag SHALL clear on handoff.
REQ-012 PC_modified in REQ, WAIT or HOLD without same-cycle handoff SHALL capture PC_modified_data into the pending-target register; the instruction currently fetched or held is the delay slot and SHALL still be delivered.
REQ-013 HOLD without handoff SHALL keep inst_out, IF_PC and exccode_out stable.
REQ-014 Flush (empty or eret) SHALL set the target to EXC_VECTOR if empty is 1, else epc. Priority SHALL be empty > eret > PC_modified.
REQ-015 Flush SHALL clear the pending redirect, drop any held instruction and force IF_ready=0 in the next cycle.
REQ-016 Flush state transitions:
- REQ without addr_ok: stay REQ with fetch PC = target.
- REQ with addr_ok, or WAIT without data_ok: go CANCEL.
- WAIT with data_ok, or HOLD: go REQ with fetch PC = target.
- CANCEL: update target, stay CANCEL.
REQ-017 CANCEL SHALL discard the returning data; on inst_data_ok -> REQ with the latest target.
REQ-018 PC_modified SHALL be ignored in CANCEL and in any flush cycle.
REQ-019 A redirect or flush to a misaligned target SHALL be handled per REQ-007.
REQ-020 IF_PC+4 and branch arithmetic SHALL be 32-bit modulo, wrapping 32'hFFFFFFFC to 0.

Reset
REQ-021 rst_n=0 SHALL immediately set state REQ, fetch PC=RESET_PC, IF_PC=RESET_PC, inst_out=0, exccode_out=0, IF_ready=0 and pending flag 0.
REQ-022 Reset mid-transaction SHALL abandon the outstanding request; a late inst_data_ok after reset is a memory-model error, not handled.
REQ-023 After rst_n rises, inst_req=1 with inst_addr=32'hBFC00000 in the first cycle.

Verification
REQ-024 Reset release, addr_ok cycle 1, data_ok cycle 2 with 32'h24020001 -> IF_ready=1 cycle 3, IF_PC=BFC00000, then inst_addr=BFC00004.
REQ-025 HOLD with DE_enable=0 for 5 cycles -> inst_out/IF_PC stable, inst_req=0, no new fetch until DE_enable=1.
REQ-026 PC_modified=1, data 32'hBFC00100, while fetching BFC00008 -> BFC00008 delivered, then inst_addr=BFC00100.
REQ-027 empty=1 in WAIT -> CANCEL; returning data not presented (IF_ready stays 0); next inst_addr=BFC00380, pending redirect discarded.
REQ-028 eret=1 with epc=32'h80000002 -> no inst_req; IF_ready=1 with IF_PC=80000002, inst_out=0, exccode_out=5'h04.
REQ-029 empty=1 and eret=1 and PC_modified=1 in the same cycle -> next fetch address BFC00380.
